// File: rtl/vga_color_output_stage.sv
// ---------------------------------------------------------------------------
// vga_color_output_stage : RGB bit-replication expander, blanking, sync delay,
// frame-synchronous mute. Optional BG_COLOR_EN adds a mute background colour.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_color_output_stage #(
  parameter int   IN_BITS     = 2,
  parameter int   OUT_BITS    = 4,
  parameter int   PIPE_STAGES = 2,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [3*IN_BITS-1:0]  RGB,
  input  logic                  Blank,
  input  logic                  HSYNC_in,
  input  logic                  VSYNC_in,
  input  logic                  Mute_req,
`ifdef BG_COLOR_EN
  input  logic [3*OUT_BITS-1:0] Bg_rgb,
`endif
  output logic [OUT_BITS-1:0]   R,
  output logic [OUT_BITS-1:0]   G,
  output logic [OUT_BITS-1:0]   B,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic                  Mute_ack
);

  localparam int CW = 3 * IN_BITS;
`ifdef BG_COLOR_EN
  localparam int W = 4 + CW + 3 * OUT_BITS;
`else
  localparam int W = 4 + CW;
`endif
  localparam logic [W-1:0] RST_WORD = {1'b0, 1'b1, ~SYNC_ACTIVE, ~SYNC_ACTIVE, {(W-4){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACTIVE      = 2'd0,
    ST_MUTE_PEND   = 2'd1,
    ST_MUTED       = 2'd2,
    ST_UNMUTE_PEND = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   vs_prev_q;
  logic   frame_start;
  logic   mute_now;

  assign frame_start = (VSYNC_in == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
  assign mute_now    = (state_q == ST_MUTED) || (state_q == ST_UNMUTE_PEND);

  // On a frame_start cycle the Mute_req value sampled then decides directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE:      if (Mute_req) state_d = frame_start ? ST_MUTED : ST_MUTE_PEND;
      ST_MUTE_PEND:   if (!Mute_req) state_d = ST_ACTIVE;
                      else if (frame_start) state_d = ST_MUTED;
      ST_MUTED:       if (!Mute_req) state_d = frame_start ? ST_ACTIVE : ST_UNMUTE_PEND;
      ST_UNMUTE_PEND: if (Mute_req) state_d = ST_MUTED;
                      else if (frame_start) state_d = ST_ACTIVE;
      default:        state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_ACTIVE;
      vs_prev_q <= ~SYNC_ACTIVE;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= VSYNC_in;
    end
  end

  logic [W-1:0] word_in;
  logic [W-1:0] word_last;

`ifdef BG_COLOR_EN
  assign word_in = {mute_now, Blank, HSYNC_in, VSYNC_in, RGB, Bg_rgb};
`else
  assign word_in = {mute_now, Blank, HSYNC_in, VSYNC_in, RGB};
`endif

  // The output registers form the final pipe stage; earlier stages carry raw fields.
  generate
    if (PIPE_STAGES > 1) begin : g_pipe
      logic [W-1:0] stg_q [PIPE_STAGES-1];
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < PIPE_STAGES - 1; i++) stg_q[i] <= RST_WORD;
        end else begin
          stg_q[0] <= word_in;
          for (int i = 1; i < PIPE_STAGES - 1; i++) stg_q[i] <= stg_q[i-1];
        end
      end
      assign word_last = stg_q[PIPE_STAGES-2];
    end else begin : g_nopipe
      assign word_last = word_in;
    end
  endgenerate

  logic            last_mute, last_blank;
  logic [CW-1:0]   last_rgb;
  logic [3*OUT_BITS-1:0] mute_color;

  assign last_mute  = word_last[W-1];
  assign last_blank = word_last[W-2];
  assign last_rgb   = word_last[W-5 -: CW];
`ifdef BG_COLOR_EN
  assign mute_color = word_last[3*OUT_BITS-1:0];
`else
  assign mute_color = '0;
`endif

  function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] e;
    e = '0;
    for (int k = 0; k < OUT_BITS; k++) e[OUT_BITS-1-k] = c[IN_BITS-1-(k % IN_BITS)];
    return e;
  endfunction

  logic [OUT_BITS-1:0] r_d, g_d, b_d;
  logic [OUT_BITS-1:0] r_q, g_q, b_q;
  logic                hs_q, vs_q, ack_q;

  always_comb begin
    r_d = expand(last_rgb[3*IN_BITS-1 -: IN_BITS]);
    g_d = expand(last_rgb[2*IN_BITS-1 -: IN_BITS]);
    b_d = expand(last_rgb[IN_BITS-1:0]);
    if (last_blank) begin
      {r_d, g_d, b_d} = '0;
    end else if (last_mute) begin
      {r_d, g_d, b_d} = mute_color;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
      ack_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      hs_q  <= word_last[W-3];
      vs_q  <= word_last[W-4];
      ack_q <= mute_now;
    end
  end

  assign R        = r_q;
  assign G        = g_q;
  assign B        = b_q;
  assign HSYNC    = hs_q;
  assign VSYNC    = vs_q;
  assign Mute_ack = ack_q;

endmodule

`default_nettype wire
